// File: rtl/core_dbg_pkg.sv
// Shared types and defaults for the core run/verdict monitor.
package core_dbg_pkg;

    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4,
        ST_HANG    = 3'd5
    } run_status_t;

    localparam logic [31:0] DEF_TOHOST_ADDR = 32'h0000_0064;
    localparam logic [31:0] DEF_PASS_VALUE  = 32'd25;

    function automatic logic is_terminal(input run_status_t s);
        return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT) || (s == ST_HANG);
    endfunction

endpackage

// File: rtl/pc_stall_detector.sv
// Counts consecutive cycles of unchanged PC; flags when the count reaches HANG_CYCLES.
module pc_stall_detector #(
    parameter int HANG_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [31:0] pc,
    output logic        stalled
);
    localparam int SW = $clog2(HANG_CYCLES + 2);
    localparam logic [SW-1:0] LIMIT = SW'(HANG_CYCLES);

    logic [31:0]   prev_pc;
    logic          prev_vld;
    logic [SW-1:0] cnt, cnt_nxt;

    // cnt_nxt is the count including the current cycle, so the flag rises on
    // the same edge that completes the HANG_CYCLES-th stalled cycle.
    always_comb begin
        cnt_nxt = '0;
        if (prev_vld && pc == prev_pc)
            cnt_nxt = (cnt == LIMIT) ? cnt : cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_pc  <= '0;
            prev_vld <= 1'b0;
            cnt      <= '0;
        end else if (clear) begin
            prev_pc  <= pc;
            prev_vld <= 1'b0;
            cnt      <= '0;
        end else begin
            prev_pc  <= pc;
            prev_vld <= 1'b1;
            cnt      <= cnt_nxt;
        end
    end

    assign stalled = (HANG_CYCLES != 0) && !clear && (cnt_nxt == LIMIT);

endmodule

// File: rtl/core_run_monitor.sv
// Run-control and pass/fail verdict engine: holds core reset, counts RUN cycles,
// watches stores for the tohost verdict, and flags timeouts and PC hangs.
module core_run_monitor
    import core_dbg_pkg::*;
#(
    parameter int          RST_CYCLES  = 2,
    parameter int          MAX_CYCLES  = 1000,
    parameter int          HANG_CYCLES = 16,
    parameter logic [31:0] TOHOST_ADDR = DEF_TOHOST_ADDR,
    parameter logic [31:0] PASS_VALUE  = DEF_PASS_VALUE,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             MemWrite,
    input  logic [31:0]      DataAddr,
    input  logic [31:0]      WriteData,
    input  logic [31:0]      PC,
    output logic             core_reset,
    output logic             done,
    output logic             pass,
    output logic [2:0]       status,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] store_count
);
    localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HW-1:0]    HOLD_LAST = HW'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_M1    = CNT_W'(MAX_CYCLES - 1);

    run_status_t   state, state_nxt;
    logic [HW-1:0] hold_cnt;
    logic          stalled, tohost_hit, budget_hit;

    assign tohost_hit = MemWrite && (DataAddr == TOHOST_ADDR);
    assign budget_hit = (cycle_count == MAX_M1);

    pc_stall_detector #(.HANG_CYCLES(HANG_CYCLES)) u_stall (
        .clk     (clk),
        .reset   (reset),
        .clear   (state != ST_RUN),
        .pc      (PC),
        .stalled (stalled)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_HOLD;
        else       state <= state_nxt;
    end

    // Tohost store outranks the budget so a verdict on the last cycle still counts.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_HOLD: if (hold_cnt == HOLD_LAST) state_nxt = ST_RUN;
            ST_RUN: begin
                if (tohost_hit)   state_nxt = (WriteData == PASS_VALUE) ? ST_PASS : ST_FAIL;
                else if (budget_hit) state_nxt = ST_TIMEOUT;
                else if (stalled)    state_nxt = ST_HANG;
            end
            default: if (start) state_nxt = ST_HOLD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt    <= '0;
            cycle_count <= '0;
            store_count <= '0;
        end else begin
            case (state)
                ST_HOLD: hold_cnt <= (hold_cnt == HOLD_LAST) ? '0 : hold_cnt + 1'b1;
                ST_RUN: begin
                    cycle_count <= cycle_count + 1'b1;
                    if (MemWrite && store_count != '1)
                        store_count <= store_count + 1'b1;
                end
                default: if (start) begin
                    hold_cnt    <= '0;
                    cycle_count <= '0;
                    store_count <= '0;
                end
            endcase
        end
    end

    assign core_reset = (state != ST_RUN);
    assign done       = is_terminal(state);
    assign pass       = (state == ST_PASS);
    assign status     = state;

endmodule

// File: tb/tb_core_run_monitor.sv
// Scoreboard bench for core_run_monitor: three parameterisations driven by directed programs.
module tb_core_run_monitor;

    logic        clk;
    logic        rst      [3];
    logic        start    [3];
    logic        mw       [3];
    logic [31:0] addr     [3];
    logic [31:0] wdata    [3];
    logic [31:0] pc       [3];
    logic        core_rst [3];
    logic        done     [3];
    logic        pass_o   [3];
    logic [2:0]  status   [3];
    logic [31:0] cyc      [3];
    logic [31:0] stc      [3];

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int          idx;
        logic [2:0]  st;
        logic        ps;
        logic [31:0] cc;
        logic [31:0] sc;
    } exp_t;

    exp_t exp_q[$];
    logic done_seen[3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dut0: defaults; dut1: short budget, hang detection off; dut2: 1-cycle hold, 1-cycle budget
    core_run_monitor #(.RST_CYCLES(2), .MAX_CYCLES(1000), .HANG_CYCLES(16),
                       .TOHOST_ADDR(32'h64), .PASS_VALUE(32'd25), .CNT_W(32)) dut0 (
        .clk(clk), .reset(rst[0]), .start(start[0]), .MemWrite(mw[0]), .DataAddr(addr[0]),
        .WriteData(wdata[0]), .PC(pc[0]), .core_reset(core_rst[0]), .done(done[0]),
        .pass(pass_o[0]), .status(status[0]), .cycle_count(cyc[0]), .store_count(stc[0]));

    core_run_monitor #(.RST_CYCLES(2), .MAX_CYCLES(18), .HANG_CYCLES(0),
                       .TOHOST_ADDR(32'h64), .PASS_VALUE(32'd25), .CNT_W(32)) dut1 (
        .clk(clk), .reset(rst[1]), .start(start[1]), .MemWrite(mw[1]), .DataAddr(addr[1]),
        .WriteData(wdata[1]), .PC(pc[1]), .core_reset(core_rst[1]), .done(done[1]),
        .pass(pass_o[1]), .status(status[1]), .cycle_count(cyc[1]), .store_count(stc[1]));

    core_run_monitor #(.RST_CYCLES(1), .MAX_CYCLES(1), .HANG_CYCLES(16),
                       .TOHOST_ADDR(32'h64), .PASS_VALUE(32'd25), .CNT_W(32)) dut2 (
        .clk(clk), .reset(rst[2]), .start(start[2]), .MemWrite(mw[2]), .DataAddr(addr[2]),
        .WriteData(wdata[2]), .PC(pc[2]), .core_reset(core_rst[2]), .done(done[2]),
        .pass(pass_o[2]), .status(status[2]), .cycle_count(cyc[2]), .store_count(stc[2]));

    function automatic int rst_cyc(input int i);
        return (i == 2) ? 1 : 2;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic push_exp(input int i, input logic [2:0] st, input logic ps,
                            input logic [31:0] cc, input logic [31:0] sc);
        exp_t e;
        e.idx = i; e.st = st; e.ps = ps; e.cc = cc; e.sc = sc;
        exp_q.push_back(e);
    endtask

    // Monitor: on each rising done, pop the expected verdict and compare.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (done[i] === 1'b1 && !done_seen[i]) begin
                if (exp_q.size() == 0) begin
                    check("verdict_unexpected", 32'(i), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("verdict_dut",        32'(i),           32'(e.idx));
                    check("verdict_status",     32'(status[i]),   32'(e.st));
                    check("verdict_pass",       32'(pass_o[i]),   32'(e.ps));
                    check("verdict_cycles",     cyc[i],           e.cc);
                    check("verdict_stores",     stc[i],           e.sc);
                    check("verdict_core_reset", 32'(core_rst[i]), 32'd1);
                end
            end
            done_seen[i] = (done[i] === 1'b1);
        end
    end

    // Called at a negedge just before the first hold edge; ends at a negedge in RUN.
    task automatic expect_hold(input int i);
        int r;
        r = rst_cyc(i);
        for (int k = 1; k <= r; k++) begin
            @(negedge clk);
            check("hold_core_reset", 32'(core_rst[i]), (k < r) ? 32'd1 : 32'd0);
            check("hold_status",     32'(status[i]),   (k < r) ? 32'd0 : 32'd1);
        end
    endtask

    task automatic pulse_start(input int i);
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
        check("rearm_status",     32'(status[i]),   32'd0);
        check("rearm_cycles",     cyc[i],           32'd0);
        check("rearm_stores",     stc[i],           32'd0);
        check("rearm_core_reset", 32'(core_rst[i]), 32'd1);
        check("rearm_done",       32'(done[i]),     32'd0);
        expect_hold(i);
    endtask

    // Drive up to ncyc RUN cycles; stops early once a verdict is reached.
    task automatic run_prog(input int i, input int ncyc, input int hold_from,
                            input int s1, input logic [31:0] a1, input logic [31:0] d1,
                            input int s2, input logic [31:0] a2, input logic [31:0] d2);
        for (int k = 1; k <= ncyc; k++) begin
            if (hold_from == 0)     pc[i] = 32'h40 + 32'(4 * k);
            else if (k < hold_from) pc[i] = 32'h40 - 32'(4 * (hold_from - k));
            else                    pc[i] = 32'h40;
            mw[i]    = (k == s1) || (k == s2);
            addr[i]  = (k == s2) ? a2 : a1;
            wdata[i] = (k == s2) ? d2 : d1;
            @(posedge clk);
            @(negedge clk);
            if (done[i] === 1'b1) break;
        end
        mw[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; start[i] = 1'b0; mw[i] = 1'b0;
            addr[i] = '0; wdata[i] = '0; pc[i] = '0; done_seen[i] = 1'b0;
        end
        #1;
        check("reset_status",     32'(status[0]),   32'd0);
        check("reset_core_reset", 32'(core_rst[0]), 32'd1);
        check("reset_done",       32'(done[0]),     32'd0);
        check("reset_pass",       32'(pass_o[0]),   32'd0);
        check("reset_cycles",     cyc[0],           32'd0);
        check("reset_stores",     stc[0],           32'd0);

        // dut0: pass on cycle 17
        @(negedge clk); rst[0] = 1'b0;
        expect_hold(0);
        push_exp(0, 3'd2, 1'b1, 32'd17, 32'd1);
        run_prog(0, 40, 0, 17, 32'h64, 32'd25, 0, 32'h0, 32'h0);

        // re-arm, then fail: earlier store to 0x60, verdict store of 7 on cycle 5
        pulse_start(0);
        push_exp(0, 3'd3, 1'b0, 32'd5, 32'd2);
        run_prog(0, 40, 0, 5, 32'h64, 32'd7, 2, 32'h60, 32'd9);

        // re-arm, start ignored in RUN, then async reset mid-run
        pulse_start(0);
        run_prog(0, 10, 0, 3, 32'h60, 32'd1, 0, 32'h0, 32'h0);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        check("start_in_run_status", 32'(status[0]), 32'd1);
        check("start_in_run_cycles", cyc[0],         32'd11);
        #2 rst[0] = 1'b1;
        #1;
        check("async_reset_status",     32'(status[0]),   32'd0);
        check("async_reset_core_reset", 32'(core_rst[0]), 32'd1);
        check("async_reset_cycles",     cyc[0],           32'd0);
        check("async_reset_stores",     stc[0],           32'd0);
        @(negedge clk); rst[0] = 1'b0;
        expect_hold(0);

        // PC stuck at 0x40 from cycle 3: 16th stalled cycle is cycle 19
        push_exp(0, 3'd5, 1'b0, 32'd19, 32'd0);
        run_prog(0, 60, 3, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0);

        // dut1: timeout after 18 RUN edges
        @(negedge clk); rst[1] = 1'b0;
        expect_hold(1);
        push_exp(1, 3'd4, 1'b0, 32'd18, 32'd0);
        run_prog(1, 40, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0);

        // pass store on the budget's last cycle wins over timeout
        pulse_start(1);
        push_exp(1, 3'd2, 1'b1, 32'd18, 32'd1);
        run_prog(1, 40, 0, 18, 32'h64, 32'd25, 0, 32'h0, 32'h0);

        // hang detection disabled: constant PC ends in timeout
        pulse_start(1);
        push_exp(1, 3'd4, 1'b0, 32'd18, 32'd0);
        run_prog(1, 40, 1, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0);

        // dut2: single-cycle budget, then verdict store on that only cycle
        @(negedge clk); rst[2] = 1'b0;
        expect_hold(2);
        push_exp(2, 3'd4, 1'b0, 32'd1, 32'd0);
        run_prog(2, 5, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0);
        pulse_start(2);
        push_exp(2, 3'd2, 1'b1, 32'd1, 32'd1);
        run_prog(2, 5, 0, 1, 32'h64, 32'd25, 0, 32'h0, 32'h0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
